// File: rtl/contador_pkg.sv
// Shared encodings for the mode counter and its monitor: MODO values, error codes, FSM states.
package contador_pkg;

  typedef enum logic [1:0] {
    MODO_UP    = 2'b00,
    MODO_DOWN  = 2'b01,
    MODO_DOWN3 = 2'b10,
    MODO_LOAD  = 2'b11
  } modo_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_Q    = 2'b01,
    ERR_RCO  = 2'b10,
    ERR_BOTH = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    FAIL  = 2'b10
  } state_e;

endpackage

// File: rtl/contador_model.sv
// Combinational reference of the mode counter: next Q/RCO from the current Q and controls.
module contador_model
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             ENB,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] exp_q,
  output logic             exp_rco
);

  always_comb begin
    exp_q   = Q;
    exp_rco = 1'b0;
    if (ENB) begin
      case (modo_e'(MODO))
        MODO_UP: begin
          exp_q   = Q + WIDTH'(1);
          exp_rco = &Q;
        end
        MODO_DOWN: begin
          exp_q   = Q - WIDTH'(1);
          exp_rco = (Q == '0);
        end
        MODO_DOWN3: begin
          exp_q   = Q - WIDTH'(3);
          exp_rco = (Q < WIDTH'(3));
        end
        default: begin
          exp_q   = D;
          exp_rco = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/contador_monitor.sv
// Passive checker for the 16-bit mode counter: predicts Q/RCO each cycle and flags mismatches.
// Optional coverage counters enabled with `define CONTADOR_MONITOR_COVER_EN.
module contador_monitor
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ERR_CNT_W = 8,
  parameter int unsigned STICKY    = 0
) (
  input  logic                 CLK,
  input  logic                 RESET_L,
  input  logic                 ENB,
  input  logic [1:0]           MODO,
  input  logic [WIDTH-1:0]     D,
  input  logic [WIDTH-1:0]     Q,
  input  logic                 RCO,
  output logic                 chk_valid,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 fail
`ifdef CONTADOR_MONITOR_COVER_EN
  ,
  output logic [ERR_CNT_W-1:0] cov_mode0,
  output logic [ERR_CNT_W-1:0] cov_mode1,
  output logic [ERR_CNT_W-1:0] cov_mode2,
  output logic [ERR_CNT_W-1:0] cov_mode3,
  output logic [ERR_CNT_W-1:0] cov_wrap
`endif
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     exp_q_r, pred_q;
  logic                 exp_rco_r, pred_rco;
  logic                 q_bad, rco_bad;
  logic                 chk_d, err_d;
  err_e                 code_d;
  logic [ERR_CNT_W-1:0] cnt_d;

  contador_model #(.WIDTH(WIDTH)) u_model (
    .ENB     (ENB),
    .MODO    (MODO),
    .D       (D),
    .Q       (Q),
    .exp_q   (pred_q),
    .exp_rco (pred_rco)
  );

  // Prediction always comes from the observed Q, so one glitch yields one error.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      exp_q_r   <= '0;
      exp_rco_r <= 1'b0;
    end else begin
      exp_q_r   <= pred_q;
      exp_rco_r <= pred_rco;
    end
  end

  // Case-inequality so X/Z on the counter outputs is reported as a mismatch.
  assign q_bad   = (Q !== exp_q_r);
  assign rco_bad = (RCO !== exp_rco_r);

  always_comb begin
    state_d = state_q;
    chk_d   = 1'b0;
    err_d   = 1'b0;
    code_d  = ERR_NONE;
    cnt_d   = err_count;
    case (state_q)
      IDLE: state_d = CHECK;
      CHECK: begin
        chk_d = 1'b1;
        if (q_bad || rco_bad) begin
          err_d  = 1'b1;
          code_d = err_e'({rco_bad, q_bad});
          if (err_count != '1) cnt_d = err_count + ERR_CNT_W'(1);
          if (STICKY != 0) state_d = FAIL;
        end
      end
      FAIL: state_d = FAIL;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q   <= IDLE;
      chk_valid <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      chk_valid <= chk_d;
      err       <= err_d;
      err_code  <= code_d;
      err_count <= cnt_d;
    end
  end

  assign fail = (state_q == FAIL);

`ifdef CONTADOR_MONITOR_COVER_EN
  logic [ERR_CNT_W-1:0] cov_m [4];
  logic [ERR_CNT_W-1:0] cov_w;

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      for (int unsigned i = 0; i < 4; i++) cov_m[i] <= '0;
      cov_w <= '0;
    end else if (state_q == CHECK) begin
      if (ENB && (cov_m[MODO] != '1)) cov_m[MODO] <= cov_m[MODO] + ERR_CNT_W'(1);
      if ((RCO === 1'b1) && (cov_w != '1)) cov_w <= cov_w + ERR_CNT_W'(1);
    end
  end

  assign cov_mode0 = cov_m[0];
  assign cov_mode1 = cov_m[1];
  assign cov_mode2 = cov_m[2];
  assign cov_mode3 = cov_m[3];
  assign cov_wrap  = cov_w;
`endif

endmodule

// File: tb/tb_contador_monitor.sv
// Directed bench for contador_monitor: default, sticky and narrow-counter instances share one stimulus.
module tb_contador_monitor;
  import contador_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET_L;
  logic        ENB;
  logic [1:0]  MODO;
  logic [15:0] D;
  logic [15:0] Q;
  logic        RCO;

  logic       v0, e0, f0, v1, e1, f1, v2, e2, f2;
  logic [1:0] c0, c1, c2;
  logic [7:0] n0, n1;
  logic [1:0] n2;

  int total = 0;
  int bad   = 0;

`ifdef CONTADOR_MONITOR_COVER_EN
  logic [7:0] cv0 [5];
  logic [7:0] cv1 [5];
  logic [1:0] cv2 [5];
`endif

  contador_monitor #(.WIDTH(16), .ERR_CNT_W(8), .STICKY(0)) dut0 (
    .CLK(CLK), .RESET_L(RESET_L), .ENB(ENB), .MODO(MODO), .D(D), .Q(Q), .RCO(RCO),
    .chk_valid(v0), .err(e0), .err_code(c0), .err_count(n0), .fail(f0)
`ifdef CONTADOR_MONITOR_COVER_EN
    , .cov_mode0(cv0[0]), .cov_mode1(cv0[1]), .cov_mode2(cv0[2]), .cov_mode3(cv0[3]), .cov_wrap(cv0[4])
`endif
  );

  contador_monitor #(.WIDTH(16), .ERR_CNT_W(8), .STICKY(1)) dut1 (
    .CLK(CLK), .RESET_L(RESET_L), .ENB(ENB), .MODO(MODO), .D(D), .Q(Q), .RCO(RCO),
    .chk_valid(v1), .err(e1), .err_code(c1), .err_count(n1), .fail(f1)
`ifdef CONTADOR_MONITOR_COVER_EN
    , .cov_mode0(cv1[0]), .cov_mode1(cv1[1]), .cov_mode2(cv1[2]), .cov_mode3(cv1[3]), .cov_wrap(cv1[4])
`endif
  );

  contador_monitor #(.WIDTH(16), .ERR_CNT_W(2), .STICKY(0)) dut2 (
    .CLK(CLK), .RESET_L(RESET_L), .ENB(ENB), .MODO(MODO), .D(D), .Q(Q), .RCO(RCO),
    .chk_valid(v2), .err(e2), .err_code(c2), .err_count(n2), .fail(f2)
`ifdef CONTADOR_MONITOR_COVER_EN
    , .cov_mode0(cv2[0]), .cov_mode1(cv2[1]), .cov_mode2(cv2[2]), .cov_mode3(cv2[3]), .cov_wrap(cv2[4])
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one cycle of counter controls/outputs, then sample just after the edge.
  task automatic step(input logic [15:0] q, input logic rco, input logic enb,
                      input logic [1:0] modo, input logic [15:0] d);
    Q = q; RCO = rco; ENB = enb; MODO = modo; D = d;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] q;
    RESET_L = 1'b0; ENB = 1'b0; MODO = 2'b00; D = '0; Q = '0; RCO = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_valid", v0, 0);
    chk("rst_err", e0, 0);
    chk("rst_code", c0, 0);
    chk("rst_count", n0, 0);
    chk("rst_fail", f0, 0);

    // Load 0x1234, then count up with a correct counter.
    RESET_L = 1'b1;
    step(16'h0000, 0, 1, 2'b11, 16'h1234);
    chk("idle_valid", v0, 0);
    step(16'h1234, 0, 1, 2'b00, 16'h0000);
    chk("first_valid", v0, 1);
    chk("load_err", e0, 0);
    step(16'h1235, 0, 1, 2'b00, 16'h0000);
    chk("up1_err", e0, 0);
    step(16'h1236, 0, 1, 2'b00, 16'h0000);
    chk("up2_err", e0, 0);
    step(16'h1237, 0, 1, 2'b00, 16'h0000);
    chk("up3_err", e0, 0);
    chk("up_count", n0, 0);

    // Wrap FFFF -> 0000 with RCO=1 is legal.
    step(16'h1238, 0, 1, 2'b11, 16'hFFFF);
    step(16'hFFFF, 0, 1, 2'b00, 16'h0000);
    step(16'h0000, 1, 1, 2'b00, 16'h0000);
    chk("wrap_ok_err", e0, 0);
    chk("wrap_ok_count", n0, 0);
    // Same wrap, RCO missing.
    step(16'h0001, 0, 1, 2'b11, 16'hFFFF);
    step(16'hFFFF, 0, 1, 2'b00, 16'h0000);
    step(16'h0000, 0, 1, 2'b11, 16'h0001);
    chk("wrap_bad_err", e0, 1);
    chk("wrap_bad_code", c0, 2'b10);
    chk("wrap_bad_count", n0, 1);

    // DOWN3 from 0001 predicts FFFE/RCO=1; counter gives FFFD instead.
    step(16'h0001, 0, 1, 2'b10, 16'h0000);
    chk("down3_pre_err", e0, 0);
    chk("err_pulse_width", e0, 0);
    step(16'hFFFD, 1, 1, 2'b10, 16'h0000);
    chk("down3_err", e0, 1);
    chk("down3_code", c0, 2'b01);
    chk("down3_count", n0, 2);
    step(16'hFFFA, 0, 1, 2'b11, 16'h00A0);
    chk("down3_resync_err", e0, 0);
    chk("down3_resync_count", n0, 2);

    // Hold with ENB=0, then one spurious change.
    step(16'h00A0, 0, 0, 2'b00, 16'h0000);
    chk("hold0_err", e0, 0);
    for (int i = 0; i < 3; i++) begin
      step(16'h00A0, 0, 0, 2'b00, 16'h0000);
      chk("hold_err", e0, 0);
    end
    step(16'h00A1, 0, 0, 2'b00, 16'h0000);
    chk("hold_glitch_err", e0, 1);
    chk("hold_glitch_code", c0, 2'b01);
    step(16'h00A1, 0, 0, 2'b00, 16'h0000);
    chk("hold_after_err", e0, 0);
    chk("hold_count", n0, 3);
    chk("nonsticky_fail", f0, 0);

    // Sticky instance: double mismatch locks FAIL.
    RESET_L = 1'b0;
    #2;
    RESET_L = 1'b1;
    step(16'h0000, 0, 1, 2'b11, 16'h0050);
    step(16'h0050, 0, 1, 2'b00, 16'h0000);
    chk("sticky_pre_err", e1, 0);
    chk("sticky_pre_fail", f1, 0);
    step(16'h0060, 1, 1, 2'b00, 16'h0000);
    chk("sticky_err", e1, 1);
    chk("sticky_code", c1, 2'b11);
    chk("sticky_count", n1, 1);
    chk("sticky_fail", f1, 1);
    step(16'h0061, 0, 1, 2'b00, 16'h0000);
    chk("fail_valid", v1, 0);
    chk("fail_err", e1, 0);
    chk("fail_hold", f1, 1);
    step(16'h0000, 1, 1, 2'b00, 16'h0000);
    chk("fail_frozen_count", n1, 1);
    chk("fail_frozen_err", e1, 0);
    #3;
    RESET_L = 1'b0;
    #1;
    chk("async_fail", f1, 0);
    chk("async_count", n1, 0);
    chk("async_code", c1, 0);
    chk("async_valid0", v0, 0);
    chk("async_count0", n0, 0);

    // Narrow counter saturates at 3 after five mismatches.
    @(posedge CLK);
    #1;
    RESET_L = 1'b1;
    step(16'h0000, 0, 1, 2'b11, 16'h0010);
    step(16'h0010, 0, 1, 2'b00, 16'h0000);
    q = 16'h0020;
    for (int i = 0; i < 5; i++) begin
      step(q, 0, 1, 2'b00, 16'h0000);
      chk("sat_err", e2, 1);
      q = q + 16'd2;
    end
    chk("sat_count", n2, 3);
    chk("wide_count", n0, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
